uart_rx: RTL
============

# uart_rx

Oversampling UART receiver: recovers 8N1 frames from the asynchronous RS-232 line and emits each byte with a one-cycle valid strobe. Sits directly upstream of the UART RX FIFO. It is clocked by the RX sample clock, which runs at `UART_RX_SAMPLE_RATE` × baud. `data_o`/`valid_o` connect straight to the FIFO write data and write enable.

## Interface
- `DATA_LENGTH`, default `UART_DATA_LENGTH` (8): data bits per frame, LSB first.
- `SAMPLE_RATE`, default `UART_RX_SAMPLE_RATE` (16): sample clocks per bit; even, ≥ 8.

- `clk_i`  in  1  RX sample clock (SAMPLE_RATE × baud).
- `rst_i`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  raw serial line, asynchronous, idle high.
- `data_o`  out  DATA_LENGTH  last received byte; held until next valid frame.
- `valid_o`  out  1  one-cycle pulse, `data_o` valid in the same cycle.
- `frame_err_o`  out  1  one-cycle pulse when stop bit sampled low.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1) into `rx_s`.
- A 3-bit history `rx_h` of `rx_s` is kept, reset to 3'b111. The bit value is `maj(rx_h)`, the majority of 3.
- `tick` counter, width `$clog2(SAMPLE_RATE)`. `bit_cnt` counter, width `$clog2(DATA_LENGTH+1)`. Shift register `sh`, DATA_LENGTH bits, right-shift with new bit into MSB.
- States:
  - IDLE: `tick`=0. On `rx_s`==0, go to START.
  - START: `tick` increments. At `tick`==SAMPLE_RATE/2−1:
    - if `maj(rx_h)`==0, go to DATA with `tick`=0 and `bit_cnt`=0;
    - otherwise this is a false start; return to IDLE.
  - DATA: `tick` increments and wraps at SAMPLE_RATE−1. At `tick`==SAMPLE_RATE−1, shift `maj(rx_h)` into `sh` and increment `bit_cnt`. When `bit_cnt` reaches DATA_LENGTH−1 and the sample is taken, go to STOP with `tick`=0.
  - STOP: at `tick`==SAMPLE_RATE−1, sample `maj(rx_h)`:
    - 1: `data_o`←`sh`, pulse `valid_o`, go to IDLE;
    - 0: pulse `frame_err_o`, leave `data_o` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- `valid_o` and `frame_err_o` are mutually exclusive, and each is at most one cycle per frame.
- No parity support. Exactly one stop bit is checked. Extra stop time is absorbed in IDLE.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `frame_err_o`=0, `busy_o`=0, state IDLE, all counters 0.
- All outputs are registered. `busy_o` is decoded from the registered state.
- Synchronizer latency is 2 cycles from the `rx_i` edge to `rx_s`.
- Start-bit edge on `rx_s` to `valid_o` is SAMPLE_RATE/2 + (DATA_LENGTH+1)·SAMPLE_RATE cycles (152 for 16/8), ±1 cycle.
- A back-to-back frame with its start edge immediately after the stop-bit midpoint is accepted, because the block returns to IDLE half a bit before the stop bit ends.
- A glitch low shorter than SAMPLE_RATE/2−1 cycles returns the block to IDLE with no output.
- A single-cycle glitch inside a data bit, at a sample point, is rejected by the majority vote.
- Reset asserted mid-frame immediately forces the reset values. A partial frame is never emitted.

## Structure
- `uart.vh` holds `UART_DATA_LENGTH`, `UART_RX_SAMPLE_RATE` and the state encoding `UART_RX_IDLE/START/DATA/STOP/WAIT_IDLE`, 3 bits.
- Sub-module `sync_2ff` is a generic 2-flop synchronizer with a reset-value parameter, reusable for `rs232_rx_i`.
- Everything else lives in `uart_rx`: FSM, counters, history, shift register.

## Test plan
All scenarios use SAMPLE_RATE=16 and DATA_LENGTH=8.
- Send frame 0xA5 at nominal rate → exactly one `valid_o` pulse with `data_o`=0xA5, `frame_err_o` never high, `busy_o` low afterwards.
- Drive `rx_i` low for 4 cycles, then high → no `valid_o`/`frame_err_o`, `busy_o` falls within 10 cycles, state IDLE.
- Send 0x3C with the stop bit held low for 3 bit times, then high, then send 0x5A → one `frame_err_o` pulse, `data_o` stays at its prior value, then `valid_o` with `data_o`=0x5A.
- Send 0x00 and 0xFF back-to-back with a 1-bit stop → two `valid_o` pulses 160±1 cycles apart with values 0x00 then 0xFF.
- Send 0x81 with a 1-cycle inverted glitch at the sample point of bit 3 → `valid_o` with `data_o`=0x81.
- Assert `rst_i` low during bit 4 of 0x55, release, then send 0x96 → all outputs 0 during reset, no pulse for the aborted frame, then `valid_o` with `data_o`=0x96.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive constants, state encoding and the 3-sample majority vote.
package uart_rx_pkg;

  localparam int UART_DATA_LENGTH    = 8;
  localparam int UART_RX_SAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_STOP      = 3'd3,
    UART_RX_WAIT_IDLE = 3'd4
  } uart_rx_state_e;

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: start-bit qualification, mid-bit majority
// sampling, one stop bit checked, break held off in WAIT_IDLE.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_LENGTH = UART_DATA_LENGTH,
  parameter int SAMPLE_RATE = UART_RX_SAMPLE_RATE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  output logic [DATA_LENGTH-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   busy_o
);

  localparam int TICK_W = $clog2(SAMPLE_RATE);
  localparam int CNT_W  = $clog2(DATA_LENGTH + 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_RATE - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_LENGTH - 1);

  uart_rx_state_e         state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_LENGTH-1:0] sh_q, sh_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [2:0]             rx_h_q, rx_h_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_s;
  logic                   bit_val;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign bit_val = maj3(rx_h_q);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_h_d      = {rx_h_q[1:0], rx_s};

    unique case (state_q)
      UART_RX_IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = UART_RX_START;
      end
      UART_RX_START: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          if (!bit_val) begin
            bit_cnt_d = '0;
            state_d   = UART_RX_DATA;
          end else begin
            state_d = UART_RX_IDLE;
          end
        end
      end
      UART_RX_DATA: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          sh_d      = {bit_val, sh_q[DATA_LENGTH-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) state_d = UART_RX_STOP;
        end
      end
      UART_RX_STOP: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_val) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = UART_RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = UART_RX_WAIT_IDLE;
          end
        end
      end
      UART_RX_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start is accepted.
        tick_d = '0;
        if (rx_s) state_d = UART_RX_IDLE;
      end
      default: state_d = UART_RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= UART_RX_IDLE;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      rx_h_q      <= 3'b111;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      rx_h_q      <= rx_h_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != UART_RX_IDLE);

endmodule
